// File: rtl/conv_mac_engine_if.sv
// Signal bundle for conv_mac_engine: weight load, sample stream, result handshake and status.
interface conv_mac_engine_if #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 9,
    parameter int LANES  = 3
);
    localparam int ACC_W = 2*DATA_W + $clog2(TAPS);

    logic                    wValid;
    logic [LANES*DATA_W-1:0] wData;
    logic                    cStart;
    logic                    inValid;
    logic                    inReady;
    logic [DATA_W-1:0]       inData;
    logic                    sumValid;
    logic                    sumReady;
    logic [LANES*ACC_W-1:0]  sum;
    logic                    busy;
    logic                    FULL;
    logic                    EMPTY;
    logic                    satFlag;

    modport master (
        output wValid, wData, cStart, inValid, inData, sumReady,
        input  inReady, sumValid, sum, busy, FULL, EMPTY, satFlag
    );

    modport slave (
        input  wValid, wData, cStart, inValid, inData, sumReady,
        output inReady, sumValid, sum, busy, FULL, EMPTY, satFlag
    );
endinterface

// File: rtl/conv_mac_engine.sv
// Streaming MAC engine: sample FIFO broadcast to LANES dot-product lanes of TAPS stored weights.
// Define MAC_SATURATE_EN to clamp each lane result to the 2*DATA_W signed range and raise satFlag.
module conv_mac_engine #(
    parameter int DATA_W     = 16,
    parameter int TAPS       = 9,
    parameter int LANES      = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    conv_mac_engine_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(TAPS);
    localparam int PW    = 2*DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TW    = $clog2(TAPS);
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS-1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   stop_q, stop_d;
    logic   wloaded_q, wloaded_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] widx_q, widx_d, tap_cnt_q, tap_cnt_d;
    logic signed [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic signed [DATA_W-1:0] fifo_d [FIFO_DEPTH];
    logic signed [DATA_W-1:0] weight_q [LANES][TAPS];
    logic signed [DATA_W-1:0] weight_d [LANES][TAPS];

    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [TW-1:0]            tap_p1_q, tap_p1_d, tap_p2_q, tap_p2_d;
    logic signed [DATA_W-1:0] smp_p1_q, smp_p1_d;
    logic signed [PW-1:0]     prod_p2_q [LANES];
    logic signed [PW-1:0]     prod_p2_d [LANES];
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];
    logic signed [ACC_W-1:0]  sum_q [LANES];
    logic signed [ACC_W-1:0]  sum_d [LANES];
    logic                     sum_valid_q, sum_valid_d;

    logic full, empty, push, pop, stall, accept;
    logic signed [PW-1:0]    op_a, op_b;
    logic signed [ACC_W-1:0] lane_res;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};

    logic sat_q, sat_d;

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction
`endif

    always_comb begin
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty  = (wr_ptr_q == rd_ptr_q);
        stall  = sum_valid_q && !bus.sumReady;
        accept = sum_valid_q && bus.sumReady;
        push   = bus.inValid && !full;
        // A pending stop blocks further pops so the next window never starts.
        pop    = (state_q == RUN) && !empty && !stall && !stop_q;
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[AW-1:0]] = bus.inData;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        weight_d  = weight_q;
        widx_d    = widx_q;
        wloaded_d = wloaded_q;
        if (state_q == IDLE && bus.wValid) begin
            for (int l = 0; l < LANES; l++) begin
                weight_d[l][widx_q] = bus.wData[l*DATA_W +: DATA_W];
            end
            widx_d = (widx_q == LAST_TAP) ? '0 : widx_q + 1'b1;
            if (widx_q == LAST_TAP) wloaded_d = 1'b1;
        end

        state_d   = state_q;
        stop_d    = stop_q;
        tap_cnt_d = tap_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.cStart && wloaded_q) begin
                    state_d = RUN;
                    stop_d  = 1'b0;
                end
            end
            default: begin
                if (pop) begin
                    tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + 1'b1;
                    if (tap_cnt_q == LAST_TAP && !bus.cStart) stop_d = 1'b1;
                end
                // Leave only once the final window has drained and its sum is taken.
                if (stop_q && !vld_p1_q && !vld_p2_q && accept) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        // c0 -> c1: popped sample and its tap index
        vld_p1_d = pop;
        tap_p1_d = tap_cnt_q;
        smp_p1_d = pop ? fifo_q[rd_ptr_q[AW-1:0]] : smp_p1_q;

        // c1 -> c2: per-lane products
        vld_p2_d = vld_p1_q;
        tap_p2_d = tap_p1_q;
        op_a     = {{DATA_W{smp_p1_q[DATA_W-1]}}, smp_p1_q};
        op_b     = '0;
        for (int l = 0; l < LANES; l++) begin
            op_b         = {{DATA_W{weight_q[l][tap_p1_q][DATA_W-1]}}, weight_q[l][tap_p1_q]};
            prod_p2_d[l] = vld_p1_q ? op_a * op_b : prod_p2_q[l];
        end

        // c2 -> c3: accumulate, load sum on the last tap
        sum_valid_d = accept ? 1'b0 : sum_valid_q;
`ifdef MAC_SATURATE_EN
        sat_d = sat_q;
`endif
        lane_res = '0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
            sum_d[l] = sum_q[l];
            if (vld_p2_q) begin
                lane_res = ((tap_p2_q == '0) ? '0 : acc_q[l])
                         + {{(ACC_W-PW){prod_p2_q[l][PW-1]}}, prod_p2_q[l]};
                acc_d[l] = lane_res;
                if (tap_p2_q == LAST_TAP) begin
`ifdef MAC_SATURATE_EN
                    sum_d[l] = sat_clamp(lane_res);
                    if (sat_hit(lane_res)) sat_d = 1'b1;
`else
                    sum_d[l] = lane_res;
`endif
                end
            end
        end
        if (vld_p2_q && tap_p2_q == LAST_TAP) sum_valid_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
            wloaded_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            widx_q      <= '0;
            tap_cnt_q   <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            tap_p1_q    <= '0;
            tap_p2_q    <= '0;
            smp_p1_q    <= '0;
            sum_valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            for (int l = 0; l < LANES; l++) begin
                for (int t = 0; t < TAPS; t++) weight_q[l][t] <= '0;
                prod_p2_q[l] <= '0;
                acc_q[l]     <= '0;
                sum_q[l]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            stop_q      <= stop_d;
            wloaded_q   <= wloaded_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            widx_q      <= widx_d;
            tap_cnt_q   <= tap_cnt_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            tap_p1_q    <= tap_p1_d;
            tap_p2_q    <= tap_p2_d;
            smp_p1_q    <= smp_p1_d;
            sum_valid_q <= sum_valid_d;
            fifo_q      <= fifo_d;
            weight_q    <= weight_d;
            prod_p2_q   <= prod_p2_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
        end
    end

`ifdef MAC_SATURATE_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) sat_q <= 1'b0;
        else      sat_q <= sat_d;
    end
    assign bus.satFlag = sat_q;
`else
    assign bus.satFlag = 1'b0;
`endif

    always_comb begin
        bus.inReady  = !full;
        bus.FULL     = full;
        bus.EMPTY    = empty;
        bus.busy     = busy_q;
        bus.sumValid = sum_valid_q;
        bus.sum      = '0;
        for (int l = 0; l < LANES; l++) bus.sum[l*ACC_W +: ACC_W] = sum_q[l];
    end
endmodule
